// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Opcode, funct and ALU-control encodings for the mips core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/mips_regfile.sv
// ============================================================================
//  Module      : mips_regfile
//  Description : 32x32 register file, two async read ports, one sync write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we3,
  input  logic [4:0]  wa3,
  input  logic [31:0] wd3
);

  logic [31:0] r_regs [32];

  // Reset has priority so a write in flight on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we3 && (wa3 != 5'd0)) begin
      r_regs[wa3] <= wd3;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : r_regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : r_regs[ra2];

endmodule : mips_regfile

`default_nettype wire

// File: rtl/mips.sv
// ============================================================================
//  Module      : mips
//  Description : Single-cycle 32-bit MIPS core (external imem/dmem).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        memwrite,
  output logic [31:0] aluout,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  logic [31:0] r_pc;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [25:0] w_addr;
  logic        w_unused_shamt;

  logic        w_valid;
  logic        w_regwrite;
  logic        w_regdst;
  logic        w_alusrc;
  logic        w_zeroext;
  logic        w_memtoreg;
  logic        w_memwrite;
  logic        w_branch;
  logic        w_jump;
  alu_ctrl_t   w_aluctrl;

  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_immext;
  logic [31:0] w_srcb;
  logic [31:0] w_aluresult;
  logic [31:0] w_result;
  logic [4:0]  w_writereg;
  logic [31:0] w_pcplus4;
  logic [31:0] w_pcbranch;
  logic [31:0] w_pcnext;

  assign w_op           = instr[31:26];
  assign w_rs           = instr[25:21];
  assign w_rt           = instr[20:16];
  assign w_rd           = instr[15:11];
  assign w_funct        = instr[5:0];
  assign w_imm          = instr[15:0];
  assign w_addr         = instr[25:0];
  assign w_unused_shamt = ^instr[10:6];

  // Unrecognised opcode/funct falls through the defaults as a no-op.
  always_comb begin
    w_valid    = 1'b0;
    w_regwrite = 1'b0;
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_zeroext  = 1'b0;
    w_memtoreg = 1'b0;
    w_memwrite = 1'b0;
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    w_aluctrl  = ALU_ADD;
    case (w_op)
      OP_RTYPE: begin
        w_regdst = 1'b1;
        case (w_funct)
          FUNCT_ADD: begin w_valid = 1'b1; w_aluctrl = ALU_ADD; end
          FUNCT_SUB: begin w_valid = 1'b1; w_aluctrl = ALU_SUB; end
          FUNCT_AND: begin w_valid = 1'b1; w_aluctrl = ALU_AND; end
          FUNCT_OR:  begin w_valid = 1'b1; w_aluctrl = ALU_OR;  end
          FUNCT_SLT: begin w_valid = 1'b1; w_aluctrl = ALU_SLT; end
          default:   w_valid = 1'b0;
        endcase
        w_regwrite = w_valid;
      end
      OP_ADDI: begin
        w_valid = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1;
      end
      OP_ORI: begin
        w_valid = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1;
        w_zeroext = 1'b1; w_aluctrl = ALU_OR;
      end
      OP_SLTI: begin
        w_valid = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1;
        w_aluctrl = ALU_SLT;
      end
      OP_LW: begin
        w_valid = 1'b1; w_regwrite = 1'b1; w_alusrc = 1'b1;
        w_memtoreg = 1'b1;
      end
      OP_SW: begin
        w_valid = 1'b1; w_alusrc = 1'b1; w_memwrite = 1'b1;
      end
      OP_BEQ: begin
        w_valid = 1'b1; w_branch = 1'b1; w_aluctrl = ALU_SUB;
      end
      OP_J: begin
        w_valid = 1'b1; w_jump = 1'b1;
      end
      default: w_valid = 1'b0;
    endcase
  end

  assign w_writereg = w_regdst ? w_rd : w_rt;
  assign w_result   = w_memtoreg ? readdata : w_aluresult;

  mips_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (w_rs),
    .ra2   (w_rt),
    .rd1   (w_rd1),
    .rd2   (w_rd2),
    .we3   (w_regwrite),
    .wa3   (w_writereg),
    .wd3   (w_result)
  );

  assign w_immext = w_zeroext ? {16'd0, w_imm} : {{16{w_imm[15]}}, w_imm};
  assign w_srcb   = w_alusrc ? w_immext : w_rd2;

  always_comb begin
    w_aluresult = 32'd0;
    case (w_aluctrl)
      ALU_AND: w_aluresult = w_rd1 & w_srcb;
      ALU_OR:  w_aluresult = w_rd1 | w_srcb;
      ALU_ADD: w_aluresult = w_rd1 + w_srcb;
      ALU_SUB: w_aluresult = w_rd1 - w_srcb;
      ALU_SLT: w_aluresult = {31'd0, $signed(w_rd1) < $signed(w_srcb)};
      default: w_aluresult = 32'd0;
    endcase
  end

  assign w_pcplus4  = r_pc + 32'd4;
  assign w_pcbranch = w_pcplus4 + {w_immext[29:0], 2'b00};

  always_comb begin
    w_pcnext = w_pcplus4;
    if (w_jump) begin
      w_pcnext = {w_pcplus4[31:28], w_addr, 2'b00};
    end else if (w_branch && (w_aluresult == 32'd0)) begin
      w_pcnext = w_pcbranch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pcnext;
    end
  end

  assign pc        = r_pc;
  assign aluout    = w_valid ? w_aluresult : 32'd0;
  assign writedata = w_rd2;
  assign memwrite  = w_memwrite & ~reset;

endmodule : mips

`default_nettype wire

// File: tb/tb_mips.sv
// ============================================================================
//  Module      : tb_mips
//  Description : Directed-vector scoreboard bench for the mips core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  mips #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        mw;
    logic        chk_alu;
    logic [31:0] alu;
    logic        chk_wd;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] rt_i(input int rs, input int rt, input int rd,
                                       input logic [5:0] fn);
    logic [4:0] a, b, c;
    a = 5'(rs); b = 5'(rt); c = 5'(rd);
    return {6'b000000, a, b, c, 5'd0, fn};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input int rs, input int rt,
                                       input logic [15:0] imm);
    logic [4:0] a, b;
    a = 5'(rs); b = 5'(rt);
    return {op, a, b, imm};
  endfunction

  function automatic logic [31:0] j_i(input logic [25:0] addr);
    return {6'b000010, addr};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: each negedge the DUT presents the current instruction's outputs.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".pc"}, pc, e.pc);
      chk({e.name, ".memwrite"}, {31'd0, memwrite}, {31'd0, e.mw});
      if (e.chk_alu) chk({e.name, ".aluout"}, aluout, e.alu);
      if (e.chk_wd)  chk({e.name, ".writedata"}, writedata, e.wd);
    end
  end

  // Issue one instruction; jmp selects a non-sequential next pc.
  task automatic issue(input string nm, input logic [31:0] ins, input logic chk_alu,
                       input logic [31:0] alu, input logic mw,
                       input logic chk_wd = 1'b0, input logic [31:0] wd = 32'd0,
                       input logic jmp = 1'b0, input logic [31:0] tgt = 32'd0,
                       input logic [31:0] rdata = 32'd0);
    exp_t e;
    instr    = ins;
    readdata = rdata;
    e.name = nm; e.pc = exp_pc; e.mw = mw;
    e.chk_alu = chk_alu; e.alu = alu; e.chk_wd = chk_wd; e.wd = wd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (reset)    exp_pc = 32'h0;
    else if (jmp) exp_pc = tgt;
    else          exp_pc = exp_pc + 32'd4;
  endtask

  initial begin
    reset = 1'b1; instr = 32'd0; readdata = 32'd0;
    @(posedge clk); #1;
    exp_pc = 32'h0;

    issue("rst_nop", 32'd0, 1'b1, 32'd0, 1'b0);
    issue("rst_sw", it_i(6'b101011, 0, 2, 16'd8), 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    issue("nop0", 32'd0, 1'b1, 32'd0, 1'b0);
    issue("nop4", 32'd0, 1'b1, 32'd0, 1'b0);
    issue("nop8", 32'd0, 1'b1, 32'd0, 1'b0);

    issue("addi_r2", it_i(6'b001000, 1, 2, 16'd2), 1'b1, 32'h2, 1'b0);
    issue("ori_r3",  it_i(6'b001101, 1, 3, 16'd4), 1'b1, 32'h4, 1'b0);
    issue("slti_r4", it_i(6'b001010, 1, 4, 16'd3), 1'b1, 32'h1, 1'b0);
    issue("addi_neg", it_i(6'b001000, 0, 6, 16'hFFFF), 1'b1, 32'hFFFF_FFFF, 1'b0);
    issue("ori_zext", it_i(6'b001101, 0, 9, 16'hFFFF), 1'b1, 32'h0000_FFFF, 1'b0);

    issue("add",  rt_i(4, 2, 3, 6'b100000), 1'b1, 32'd3, 1'b0, 1'b1, 32'd2);
    issue("sub",  rt_i(3, 4, 1, 6'b100010), 1'b1, 32'd2, 1'b0);
    issue("or",   rt_i(1, 2, 3, 6'b100101), 1'b1, 32'd2, 1'b0);
    issue("and",  rt_i(1, 2, 3, 6'b100100), 1'b1, 32'd2, 1'b0);
    issue("slt_eq", rt_i(1, 2, 3, 6'b101010), 1'b1, 32'd0, 1'b0);
    issue("addi_m1", it_i(6'b001000, 0, 1, 16'hFFFF), 1'b1, 32'hFFFF_FFFF, 1'b0);
    issue("slt_neg", rt_i(1, 2, 3, 6'b101010), 1'b1, 32'd1, 1'b0);
    issue("slt_rev", rt_i(2, 1, 3, 6'b101010), 1'b1, 32'd0, 1'b0);
    issue("sub_wrap", rt_i(0, 2, 10, 6'b100010), 1'b1, 32'hFFFF_FFFE, 1'b0);

    issue("sw", it_i(6'b101011, 0, 2, 16'd8), 1'b1, 32'd8, 1'b1, 1'b1, 32'd2);
    issue("sw_norw", rt_i(2, 0, 7, 6'b100000), 1'b1, 32'd2, 1'b0);
    issue("lw", it_i(6'b100011, 0, 5, 16'd8), 1'b1, 32'd8, 1'b0, 1'b0, 32'd0,
          1'b0, 32'd0, 32'h0000_1234);
    issue("lw_rd", rt_i(5, 0, 7, 6'b100000), 1'b1, 32'h1234, 1'b0);

    issue("bad_op", 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0);
    issue("bad_op_rd", rt_i(31, 0, 7, 6'b100000), 1'b1, 32'd0, 1'b0);
    issue("bad_fn", rt_i(2, 2, 8, 6'b000000), 1'b1, 32'd0, 1'b0);
    issue("bad_fn_rd", rt_i(8, 0, 7, 6'b100000), 1'b1, 32'd0, 1'b0);

    issue("j_10", j_i(26'h4), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10);
    issue("beq_tk", it_i(6'b000100, 0, 0, 16'd3), 1'b1, 32'd0, 1'b0, 1'b0, 32'd0,
          1'b1, 32'h20);
    issue("j_10b", j_i(26'h4), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10);
    issue("beq_nt", it_i(6'b000100, 2, 0, 16'd3), 1'b1, 32'd2, 1'b0);
    issue("j_100", j_i(26'h40), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100);
    issue("j_08", j_i(26'h2), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h08);
    issue("beq_back", it_i(6'b000100, 0, 0, 16'hFFFD), 1'b1, 32'd0, 1'b0, 1'b0, 32'd0,
          1'b1, 32'h0);
    issue("j_20", j_i(26'h8), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h20);

    reset = 1'b1;
    issue("rst_addi", it_i(6'b001000, 0, 2, 16'd5), 1'b0, 32'd0, 1'b0);
    reset = 1'b0;
    issue("rst_r2", rt_i(2, 0, 7, 6'b100000), 1'b1, 32'd0, 1'b0);
    issue("rst_r5", rt_i(5, 0, 7, 6'b100000), 1'b1, 32'd0, 1'b0);
    issue("addi_r0", it_i(6'b001000, 0, 0, 16'd7), 1'b1, 32'd7, 1'b0);
    issue("r0_rd", rt_i(0, 0, 7, 6'b100000), 1'b1, 32'd0, 1'b0, 1'b1, 32'd0);

    instr = 32'd0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_mips

`default_nettype wire
